// File: rtl/vend_pkg.sv
// Shared vending-path definitions: coin codes seen by the vending FSM and the
// state encoding of the coin acceptor front end.
package vend_pkg;

  localparam logic [1:0] COIN_5    = 2'b00;
  localparam logic [1:0] COIN_10   = 2'b01;
  localparam logic [1:0] COIN_BAD  = 2'b10;
  localparam logic [1:0] COIN_IDLE = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MEASURE,
    ST_EMIT,
    ST_JAM,
    ST_HOLDOFF,
    ST_SKIP
  } caf_state_t;

endpackage

// File: rtl/coin_acceptor_front_if.sv
// Coin chute bundle: raw beam input towards the front end, coin code and
// status back towards the vending FSM.
interface coin_acceptor_front_if;

  logic       sensor_in;
  logic [1:0] coin;
  logic       coin_vld;
  logic       busy;
  logic       jam;

  modport master (output sensor_in, input coin, coin_vld, busy, jam);
  modport slave  (input sensor_in, output coin, coin_vld, busy, jam);

endinterface

// File: rtl/coin_debounce.sv
// Synchroniser plus stability filter for the beam-break sensor; db follows the
// synchronised beam only after DEBOUNCE consecutive differing samples.
module coin_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic sensor_in,
  output logic db,
  output logic db_rise,
  output logic db_fall
);

  localparam int DB_W = $clog2(DEBOUNCE + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [DB_W-1:0]        stable_cnt;
  logic                   sync_bit;

  assign sync_bit = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q     <= '0;
      stable_cnt <= '0;
      db         <= 1'b0;
      db_rise    <= 1'b0;
      db_fall    <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], sensor_in};
      db_rise <= 1'b0;
      db_fall <= 1'b0;
      if (sync_bit == db) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DB_W'(DEBOUNCE - 1)) begin
        db         <= sync_bit;
        db_rise    <= sync_bit;
        db_fall    <= ~sync_bit;
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/coin_acceptor_front.sv
// Coin acceptor front end: measures the debounced beam-break width, classifies
// it into a coin code, and guards against jams and coins arriving mid-settle.
module coin_acceptor_front
  import vend_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int W5_MIN      = 50,
  parameter int W5_MAX      = 80,
  parameter int W10_MIN     = 100,
  parameter int W10_MAX     = 140,
  parameter int TIMEOUT     = 1000,
  parameter int HOLDOFF     = 16,
  parameter int CNT_W       = 10
) (
  input logic                  clk,
  input logic                  rst,
  coin_acceptor_front_if.slave bus
);

  localparam int               HOLD_W    = $clog2(HOLDOFF + 1);
  localparam logic [CNT_W-1:0] WIDTH_MAX = CNT_W'(TIMEOUT);

  logic              db, db_rise, db_fall;
  caf_state_t        state;
  logic [CNT_W-1:0]  width;
  logic [HOLD_W-1:0] hold_cnt;
  logic [1:0]        coin_q;
  logic              coin_vld_q, busy_q, jam_q;

  coin_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE   (DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .sensor_in(bus.sensor_in),
    .db       (db),
    .db_rise  (db_rise),
    .db_fall  (db_fall)
  );

  function automatic logic [1:0] classify(input logic [CNT_W-1:0] w);
    if (w >= CNT_W'(W5_MIN) && w <= CNT_W'(W5_MAX))   return COIN_5;
    if (w >= CNT_W'(W10_MIN) && w <= CNT_W'(W10_MAX)) return COIN_10;
    return COIN_BAD;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_HOLDOFF;
      width      <= '0;
      hold_cnt   <= HOLD_W'(HOLDOFF);
      coin_q     <= COIN_IDLE;
      coin_vld_q <= 1'b0;
      busy_q     <= 1'b1;
      jam_q      <= 1'b0;
    end else begin
      coin_q     <= COIN_IDLE;
      coin_vld_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (db_rise) begin
            width  <= CNT_W'(1);
            state  <= ST_MEASURE;
            busy_q <= 1'b1;
          end
        end
        // A coin whose start was missed (SKIP) is always returned as bad.
        ST_MEASURE, ST_SKIP: begin
          if (width == WIDTH_MAX) begin
            state      <= ST_JAM;
            jam_q      <= 1'b1;
            coin_q     <= COIN_BAD;
            coin_vld_q <= 1'b1;
          end else if (db_fall) begin
            state      <= ST_EMIT;
            coin_q     <= (state == ST_SKIP) ? COIN_BAD : classify(width);
            coin_vld_q <= 1'b1;
          end else if (db) begin
            width <= width + CNT_W'(1);
          end
        end
        ST_EMIT: begin
          state    <= ST_HOLDOFF;
          hold_cnt <= HOLD_W'(HOLDOFF);
        end
        // Level test also covers a release coinciding with the timeout.
        ST_JAM: begin
          if (!db) begin
            state    <= ST_HOLDOFF;
            hold_cnt <= HOLD_W'(HOLDOFF);
            jam_q    <= 1'b0;
          end
        end
        ST_HOLDOFF: begin
          if (db_rise || (hold_cnt == HOLD_W'(1) && db)) begin
            state <= ST_SKIP;
            width <= CNT_W'(1);
          end else if (hold_cnt == HOLD_W'(1)) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - HOLD_W'(1);
          end
        end
        default: begin
          state    <= ST_HOLDOFF;
          hold_cnt <= HOLD_W'(HOLDOFF);
          busy_q   <= 1'b1;
          jam_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.coin     = coin_q;
  assign bus.coin_vld = coin_vld_q;
  assign bus.busy     = busy_q;
  assign bus.jam      = jam_q;

endmodule
